// File: rtl/decim_gate_scheduler.sv
// decim_gate_scheduler: round-robin owner of a shared decimator, issuing ratio-paced strobe bursts with holdoff
module decim_gate_scheduler #(
   parameter int RATIO_W = 4,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req,
   input  logic [RATIO_W-1:0] ratio,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [BURST_W-1:0] holdoff,
   output logic [1:0]         grant,
   output logic               strobe,
   output logic               busy,
   output logic               done,
   output logic               aborted
);
   typedef enum logic [1:0] {IDLE, SYNC, RUN, HOLD} state_t;
   localparam logic [RATIO_W:0] R_ONE = 1;
   localparam logic [BURST_W-1:0] B_ONE = 1;
   state_t state;
   logic [RATIO_W:0] period, phase, phase_inc;
   logic [BURST_W-1:0] len, cnt, hcnt;
   logic sync_cnt, last, owner_req, finish;
   logic [1:0] pick;
   always_comb begin
      owner_req = |(req & grant);
      finish = (state == SYNC && !owner_req) || (state == RUN && (!owner_req || cnt == len));
      pick = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
      phase_inc = phase + R_ONE;
   end
   // last=1 means requester 1 owned most recently, so requester 0 wins the next tie
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         grant <= '0;
         strobe <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         aborted <= 1'b0;
         period <= '0;
         phase <= '0;
         len <= '0;
         cnt <= '0;
         hcnt <= '0;
         sync_cnt <= 1'b0;
         last <= 1'b1;
      end else begin
         strobe <= 1'b0;
         done <= 1'b0;
         aborted <= 1'b0;
         if (finish) begin
            state <= HOLD;
            grant <= '0;
            done <= 1'b1;
            aborted <= !owner_req;
            hcnt <= holdoff;
         end else begin
            case (state)
               IDLE: if (|req) begin
                  state <= SYNC;
                  grant <= pick;
                  last <= pick[1];
                  busy <= 1'b1;
                  period <= {1'b0, ratio} + R_ONE;
                  len <= burst_len;
                  sync_cnt <= 1'b0;
               end
               SYNC: begin
                  sync_cnt <= 1'b1;
                  if (sync_cnt) begin
                     state <= RUN;
                     phase <= '0;
                     cnt <= '0;
                  end
               end
               RUN: begin
                  strobe <= (phase == '0);
                  cnt <= (phase == '0) ? cnt + B_ONE : cnt;
                  phase <= (phase_inc == period) ? '0 : phase_inc;
               end
               HOLD: if (hcnt == '0) begin
                  state <= IDLE;
                  busy <= 1'b0;
               end else begin
                  hcnt <= hcnt - B_ONE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/decim_gate_scheduler.md
DECIM_GATE_SCHEDULER -- requirements
Module: decim_gate_scheduler

Interface
REQ-001 The block SHALL have parameters: RATIO_W, default 4, width of the decimation ratio field; BURST_W, default 8, width of the burst-length and holdoff fields.
REQ-002 The block SHALL have ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  2  per-requester level request; held high until grant, low after done
- ratio  in  RATIO_W  decimation ratio; one strobe per ratio+1 cycles
- burst_len  in  BURST_W  number of strobes per burst
- holdoff  in  BURST_W  idle cycles after each burst
- grant  out  2  one-hot owner indication; all-zero when no owner
- strobe  out  1  single-cycle decimated enable pulse to the shared decimator datapath
- busy  out  1  high in any state other than IDLE
- done  out  1  single-cycle pulse at burst end
- aborted  out  1  valid with done; high when the burst ended by request withdrawal
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have states IDLE, SYNC, RUN and HOLD; state, counters and outputs change only on rising clk or reset.
REQ-005 In IDLE with any req bit high, the block SHALL grant exactly one requester: on a single request, that requester; on both, the one not granted last (round-robin).
REQ-006 At grant, the block SHALL latch ratio and burst_len into internal registers; later input changes SHALL NOT affect the burst in progress.
REQ-007 grant SHALL rise on the edge that leaves IDLE and SHALL stay constant until the edge that asserts done.
REQ-008 SYNC SHALL last exactly 2 cycles, matching the decimator's enable pipeline; RUN SHALL follow.
REQ-009 In RUN, a phase counter SHALL start at 0 and wrap after the latched ratio; strobe SHALL be high for one cycle each time the counter is 0.
REQ-010 The first strobe SHALL occur in the first RUN cycle, 3 cycles after grant rises; later strobes SHALL follow every ratio+1 cycles.
REQ-011 When ratio=0, strobe SHALL be high on every RUN cycle.
REQ-012 A BURST_W strobe counter SHALL count issued strobes; the cycle after the burst_len-th strobe, the block SHALL pulse done with aborted=0, clear grant and enter HOLD.
REQ-013 With latched burst_len=0, the block SHALL issue no strobe; done (aborted=0) SHALL pulse on the cycle SYNC would have passed to RUN, and the block SHALL enter HOLD.
REQ-014 If the owner's req bit is low in any SYNC or RUN cycle, the block SHALL stop strobes from the next cycle, pulse done with aborted=1, clear grant and enter HOLD.
REQ-015 The other requester's req SHALL NOT affect an active burst.
REQ-016 HOLD SHALL last holdoff cycles, sampled on HOLD entry; holdoff=0 SHALL return to IDLE on the next edge. An IDLE grant SHALL be possible on the first IDLE cycle.
REQ-017 aborted SHALL be 0 whenever done is 0.
REQ-018 The counters SHALL NOT wrap within a burst; ratio+1 arithmetic SHALL use RATIO_W+1 bits.

Reset
REQ-019 On reset high, the block SHALL asynchronously force state=IDLE, grant=00, strobe=0, busy=0, done=0, aborted=0, all counters=0, and round-robin pointer set so requester 0 wins the first contention.
REQ-020 Reset asserted mid-burst SHALL drop strobe and grant immediately with no done pulse.
REQ-021 After reset release, the first grant SHALL be possible on the first rising edge.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Single burst: req=01, ratio=3, burst_len=4, holdoff=2 -> grant=01 at G; strobes at G+3, +7, +11, +15; done at G+16 (aborted=0); busy low at G+19.
- Contention: req=11 held after reset -> grant 01 first, then 10 after HOLD, then 01; never two bits set.
- ratio=0, burst_len=3 -> strobe high 3 consecutive cycles starting G+3; done at G+6.
- burst_len=0 -> no strobe; done at G+3; grant clears.
- Abort: owner drops req after 2 strobes (ratio=1, burst_len=8) -> no further strobe; done with aborted=1 the cycle after the drop was sampled.
- Reset mid-RUN -> strobe/grant/busy 0 asynchronously; no done; fresh grant to requester 0 after release.
